// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory-access stage.
package lc3_mem_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CHAR_W = 8;

    localparam logic [DATA_W-1:0] LC3_KBSR_ADDR = 16'hFE00;
    localparam logic [DATA_W-1:0] LC3_KBDR_ADDR = 16'hFE02;
    localparam logic [DATA_W-1:0] LC3_DSR_ADDR  = 16'hFE04;
    localparam logic [DATA_W-1:0] LC3_DDR_ADDR  = 16'hFE06;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IO,
        S_STROBE,
        S_WAIT_R,
        S_WAIT_RLOW
    } mem_state_t;

    // Which memory-mapped register a latched request targets
    typedef struct packed {
        logic kbsr;
        logic kbdr;
        logic dsr;
        logic ddr;
    } io_sel_t;

endpackage

// File: rtl/mem_io_ctrl_if.sv
// CPU request, RAM and keyboard/display signals of the memory-access stage.
interface mem_io_ctrl_if;
    import lc3_mem_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_done;
    logic              cpu_err;

    logic [DATA_W-1:0] MAR;
    logic [DATA_W-1:0] MDR_in;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] MDR;
    logic              R;

    logic              kb_valid;
    logic [CHAR_W-1:0] kb_data;
    logic              kb_ack;
    logic              disp_ready;
    logic              disp_valid;
    logic [CHAR_W-1:0] disp_data;

    // Environment side: CPU, RAM array and I/O devices
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, MDR, R,
               kb_valid, kb_data, disp_ready,
        input  cpu_rdata, cpu_done, cpu_err, MAR, MDR_in, read, write,
               kb_ack, disp_valid, disp_data
    );

    // Controller side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, MDR, R,
               kb_valid, kb_data, disp_ready,
        output cpu_rdata, cpu_done, cpu_err, MAR, MDR_in, read, write,
               kb_ack, disp_valid, disp_data
    );

endinterface

// File: rtl/mem_io_ctrl_mmio_decode.sv
// Combinational decode of an address into the LC-3 memory-mapped I/O registers.
module mmio_decode
    import lc3_mem_pkg::*;
#(
    parameter logic [DATA_W-1:0] KBSR_ADDR = LC3_KBSR_ADDR,
    parameter logic [DATA_W-1:0] KBDR_ADDR = LC3_KBDR_ADDR,
    parameter logic [DATA_W-1:0] DSR_ADDR  = LC3_DSR_ADDR,
    parameter logic [DATA_W-1:0] DDR_ADDR  = LC3_DDR_ADDR
) (
    input  logic [DATA_W-1:0] addr,
    output logic              is_io,
    output logic              is_kbsr,
    output logic              is_kbdr,
    output logic              is_dsr,
    output logic              is_ddr
);

    assign is_kbsr = (addr == KBSR_ADDR);
    assign is_kbdr = (addr == KBDR_ADDR);
    assign is_dsr  = (addr == DSR_ADDR);
    assign is_ddr  = (addr == DDR_ADDR);
    assign is_io   = is_kbsr | is_kbdr | is_dsr | is_ddr;

endmodule

// File: rtl/mem_io_ctrl.sv
// LC-3 memory-access stage: one request at a time to RAM (strobe + R handshake
// with timeout) or to the locally decoded keyboard/display registers.
module mem_io_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 32,
    parameter logic [DATA_W-1:0] KBSR_ADDR      = LC3_KBSR_ADDR,
    parameter logic [DATA_W-1:0] KBDR_ADDR      = LC3_KBDR_ADDR,
    parameter logic [DATA_W-1:0] DSR_ADDR       = LC3_DSR_ADDR,
    parameter logic [DATA_W-1:0] DDR_ADDR       = LC3_DDR_ADDR
) (
    input  logic         clock,
    input  logic         reset_n,
    mem_io_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    mem_state_t        state,      state_n;
    logic [DATA_W-1:0] mar_q,      mar_n;
    logic [DATA_W-1:0] mdr_in_q,   mdr_in_n;
    logic              we_q,       we_n;
    io_sel_t           sel_q,      sel_n;
    logic [DATA_W-1:0] rdata_q,    rdata_n;
    logic              done_q,     done_n;
    logic              err_q,      err_n;
    logic              read_q,     read_n;
    logic              write_q,    write_n;
    logic              kb_ack_q,   kb_ack_n;
    logic              dvalid_q,   dvalid_n;
    logic [CHAR_W-1:0] ddata_q,    ddata_n;
    logic [CNT_W-1:0]  cnt_q,      cnt_n;
    logic              r_prev;

    logic              dec_io;
    io_sel_t           dec_sel;
    logic [CNT_W-1:0]  cnt_inc;
    logic              r_rise;

    mmio_decode #(
        .KBSR_ADDR (KBSR_ADDR),
        .KBDR_ADDR (KBDR_ADDR),
        .DSR_ADDR  (DSR_ADDR),
        .DDR_ADDR  (DDR_ADDR)
    ) u_decode (
        .addr    (bus.cpu_addr),
        .is_io   (dec_io),
        .is_kbsr (dec_sel.kbsr),
        .is_kbdr (dec_sel.kbdr),
        .is_dsr  (dec_sel.dsr),
        .is_ddr  (dec_sel.ddr)
    );

    // Only a fresh 0->1 transition of R completes an access
    assign r_rise  = bus.R & ~r_prev;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_n  = state;
        mar_n    = mar_q;
        mdr_in_n = mdr_in_q;
        we_n     = we_q;
        sel_n    = sel_q;
        rdata_n  = rdata_q;
        done_n   = 1'b0;
        err_n    = 1'b0;
        read_n   = 1'b0;
        write_n  = 1'b0;
        kb_ack_n = 1'b0;
        dvalid_n = 1'b0;
        ddata_n  = ddata_q;
        cnt_n    = cnt_q;

        case (state)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    mar_n    = bus.cpu_addr;
                    mdr_in_n = bus.cpu_wdata;
                    we_n     = bus.cpu_we;
                    sel_n    = dec_sel;
                    if (dec_io) begin
                        state_n = S_IO;
                    end else begin
                        // Strobe register is set here so it is high exactly while in STROBE
                        read_n  = ~bus.cpu_we;
                        write_n = bus.cpu_we;
                        state_n = S_STROBE;
                    end
                end
            end

            S_STROBE: begin
                cnt_n   = '0;
                state_n = S_WAIT_R;
            end

            S_WAIT_R: begin
                if (r_rise) begin
                    if (!we_q) begin
                        rdata_n = bus.MDR;
                    end
                    done_n  = 1'b1;
                    state_n = S_WAIT_RLOW;
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    cnt_n   = cnt_inc;
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                    rdata_n = '0;
                    state_n = S_WAIT_RLOW;
                end else begin
                    cnt_n = cnt_inc;
                end
            end

            S_WAIT_RLOW: begin
                if (!bus.R) begin
                    state_n = S_IDLE;
                end
            end

            S_IO: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
                if (!we_q) begin
                    if (sel_q.kbsr) begin
                        rdata_n = {bus.kb_valid, 15'b0};
                    end else if (sel_q.kbdr) begin
                        rdata_n  = {8'h00, bus.kb_data};
                        kb_ack_n = bus.kb_valid;
                    end else if (sel_q.dsr) begin
                        rdata_n = {bus.disp_ready, 15'b0};
                    end else begin
                        rdata_n = '0;
                    end
                end else if (sel_q.ddr && bus.disp_ready) begin
                    dvalid_n = 1'b1;
                    ddata_n  = mdr_in_q[CHAR_W-1:0];
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            mar_q    <= '0;
            mdr_in_q <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            kb_ack_q <= 1'b0;
            dvalid_q <= 1'b0;
            ddata_q  <= '0;
            cnt_q    <= '0;
            r_prev   <= 1'b0;
        end else begin
            state    <= state_n;
            mar_q    <= mar_n;
            mdr_in_q <= mdr_in_n;
            we_q     <= we_n;
            sel_q    <= sel_n;
            rdata_q  <= rdata_n;
            done_q   <= done_n;
            err_q    <= err_n;
            read_q   <= read_n;
            write_q  <= write_n;
            kb_ack_q <= kb_ack_n;
            dvalid_q <= dvalid_n;
            ddata_q  <= ddata_n;
            cnt_q    <= cnt_n;
            r_prev   <= bus.R;
        end
    end

    assign bus.MAR        = mar_q;
    assign bus.MDR_in     = mdr_in_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.cpu_rdata  = rdata_q;
    assign bus.cpu_done   = done_q;
    assign bus.cpu_err    = err_q;
    assign bus.kb_ack     = kb_ack_q;
    assign bus.disp_valid = dvalid_q;
    assign bus.disp_data  = ddata_q;

endmodule
